// File: rtl/stream_filter_ctrl.sv
// stream_filter_ctrl
// Fetches one compressed filter from the weight SRAM and streams it to the PE
// weight buffer through a 2-entry output FIFO with valid/ready handshake.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid/req_k/req_layer filter request (level), key = {req_layer, req_k}
//   cfg_layer_base            SRAM base address of the requested layer's filters
//   cfg_filter_len            compressed words per filter in that layer
//   mem_rd_en/mem_rd_addr     SRAM read strobe and address
//   mem_rd_data               SRAM read data, valid one cycle after mem_rd_en
//   wt_valid/wt_data/wt_last  weight stream to the PE (head of output FIFO)
//   wt_ready                  PE accepts the head word
//   stream_filter_finish      requested filter fully delivered (level)
module stream_filter_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned K_W     = 6,
  parameter int unsigned LAYER_W = 3,
  parameter int unsigned CNT_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [K_W-1:0]     req_k,
  input  logic [LAYER_W-1:0] req_layer,
  input  logic [ADDR_W-1:0]  cfg_layer_base,
  input  logic [CNT_W-1:0]   cfg_filter_len,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_rd_addr,
  input  logic [DATA_W-1:0]  mem_rd_data,
  output logic               wt_valid,
  output logic [DATA_W-1:0]  wt_data,
  output logic               wt_last,
  input  logic               wt_ready,
  output logic               stream_filter_finish
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                   r_state;
  logic [LAYER_W+K_W-1:0]   r_key;
  logic [CNT_W-1:0]         r_len;
  logic [CNT_W-1:0]         r_rd_cnt;
  logic [ADDR_W-1:0]        r_addr;
  logic                     r_inflight;
  logic                     r_inflight_last;
  logic [1:0]               r_cnt;
  logic [DATA_W-1:0]        r_data0;
  logic [DATA_W-1:0]        r_data1;
  logic                     r_last0;
  logic                     r_last1;

  logic [LAYER_W+K_W-1:0]   w_key;
  logic [ADDR_W-1:0]        w_k_ext;
  logic [ADDR_W-1:0]        w_len_ext;
  logic [ADDR_W-1:0]        w_start;
  logic                     w_accept;
  logic                     w_pop;
  logic                     w_push;
  logic [2:0]               w_occ;
  logic                     w_rd_en;
  logic                     w_rd_last;
  logic [1:0]               w_cnt_nxt;
  logic [1:0]               w_wr_idx;

  assign w_key     = {req_layer, req_k};
  // Operands widened to ADDR_W first so the product wraps modulo 2^ADDR_W.
  assign w_k_ext   = ADDR_W'(req_k);
  assign w_len_ext = ADDR_W'(cfg_filter_len);
  assign w_start   = cfg_layer_base + w_k_ext * w_len_ext;

  assign w_accept  = req_valid &&
                     ((r_state == IDLE) || ((r_state == DONE) && (w_key != r_key)));

  assign w_pop     = (r_cnt != 2'd0) && wt_ready;
  assign w_push    = r_inflight;
  // Slots committed after this cycle's pop; a new read is allowed only if it
  // still fits, so the FIFO can never overflow when the data returns.
  assign w_occ     = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en   = (r_state == ISSUE) && (w_occ < 3'd2);
  assign w_rd_last = (r_rd_cnt == r_len - CNT_W'(1));
  assign w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  // Push lands behind whatever survives this cycle's pop.
  assign w_wr_idx  = r_cnt - {1'b0, w_pop};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_key           <= '0;
      r_len           <= '0;
      r_rd_cnt        <= '0;
      r_addr          <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_cnt           <= 2'd0;
      r_data0         <= '0;
      r_data1         <= '0;
      r_last0         <= 1'b0;
      r_last1         <= 1'b0;
    end else begin
      r_inflight      <= w_rd_en;
      r_inflight_last <= w_rd_en && w_rd_last;

      if (w_rd_en) begin
        r_addr   <= r_addr + ADDR_W'(1);
        r_rd_cnt <= r_rd_cnt + CNT_W'(1);
      end

      // Head shifts on pop; a same-cycle push into entry 0 overrides the shift.
      if (w_pop) begin
        r_data0 <= r_data1;
        r_last0 <= r_last1;
      end
      if (w_push) begin
        if (w_wr_idx == 2'd0) begin
          r_data0 <= mem_rd_data;
          r_last0 <= r_inflight_last;
        end else begin
          r_data1 <= mem_rd_data;
          r_last1 <= r_inflight_last;
        end
      end
      r_cnt <= w_cnt_nxt;

      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_key    <= w_key;
            r_len    <= cfg_filter_len;
            r_addr   <= w_start;
            r_rd_cnt <= '0;
            r_state  <= (cfg_filter_len == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (w_rd_en && w_rd_last) r_state <= DRAIN;
        end
        DRAIN: begin
          // Look at post-pop occupancy so finish rises right after the last transfer.
          if ((w_cnt_nxt == 2'd0) && !r_inflight) r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_rd_en            = w_rd_en;
  assign mem_rd_addr          = r_addr;
  assign wt_valid             = (r_cnt != 2'd0);
  assign wt_data              = r_data0;
  assign wt_last              = r_last0;
  assign stream_filter_finish = (r_state == DONE);

endmodule

// File: tb/tb_stream_filter_ctrl.sv
// Testbench for stream_filter_ctrl: table-driven cycle vectors for the basic
// stream, plus directed multi-cycle sequences for stalls, re-requests,
// zero-length filters and mid-stream reset.
module tb_stream_filter_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [5:0]  req_k;
  logic [2:0]  req_layer;
  logic [11:0] cfg_layer_base;
  logic [9:0]  cfg_filter_len;
  logic        mem_rd_en;
  logic [11:0] mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic        wt_valid;
  logic [15:0] wt_data;
  logic        wt_last;
  logic        wt_ready;
  logic        stream_filter_finish;

  int n_checks = 0;
  int n_err    = 0;

  stream_filter_ctrl dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_valid            (req_valid),
    .req_k                (req_k),
    .req_layer            (req_layer),
    .cfg_layer_base       (cfg_layer_base),
    .cfg_filter_len       (cfg_filter_len),
    .mem_rd_en            (mem_rd_en),
    .mem_rd_addr          (mem_rd_addr),
    .mem_rd_data          (mem_rd_data),
    .wt_valid             (wt_valid),
    .wt_data              (wt_data),
    .wt_last              (wt_last),
    .wt_ready             (wt_ready),
    .stream_filter_finish (stream_filter_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] dval(input logic [11:0] a);
    return 16'hA500 ^ {4'h0, a};
  endfunction

  // SRAM model: data one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= dval(mem_rd_addr);
    else           mem_rd_data <= 16'hDEAD;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Issues a request at cycle 0 and follows the stream until finish rises.
  // Cycles stall_lo..stall_hi hold wt_ready low (pass -1,-1 for no stall).
  task automatic run_stream(input logic [2:0] layer, input logic [5:0] k,
                            input logic [11:0] base, input logic [9:0] len,
                            input int stall_lo, input int stall_hi);
    int          n_rd;
    int          n_xf;
    int          fin_c;
    logic [11:0] start;
    logic [11:0] first_a;
    logic [11:0] last_a;
    n_rd    = 0;
    n_xf    = 0;
    fin_c   = -1;
    first_a = '0;
    last_a  = '0;
    start   = base + 12'(k) * 12'(len);
    req_valid      = 1'b1;
    req_layer      = layer;
    req_k          = k;
    cfg_layer_base = base;
    cfg_filter_len = len;
    for (int c = 0; c < 64; c++) begin
      wt_ready = !(c >= stall_lo && c <= stall_hi);
      @(negedge clk);
      if (mem_rd_en) begin
        if (n_rd == 0) first_a = mem_rd_addr;
        last_a = mem_rd_addr;
        n_rd++;
      end
      if (wt_valid && wt_ready) begin
        chk("stream_data", wt_data, dval(start + 12'(n_xf)));
        chk("stream_last", wt_last, (n_xf == int'(len) - 1));
        n_xf++;
      end
      chk("occupancy_le_2", (n_rd - n_xf <= 2), 1);
      if (c >= stall_lo && c <= stall_hi) begin
        chk("stall_no_read", mem_rd_en, 0);
        chk("stall_valid_held", wt_valid, 1);
      end
      if (c == 1 && len != 0) chk("finish_falls", stream_filter_finish, 0);
      if (c >= 1 && stream_filter_finish) begin
        fin_c = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("finish_timeout", (fin_c >= 0), 1);
    if (fin_c >= 0) begin
      @(posedge clk);
      #1;
    end
    chk("read_count", n_rd, len);
    chk("word_count", n_xf, len);
    if (len != 0) begin
      chk("first_addr", first_a, start);
      chk("last_addr", last_a, start + 12'(len) - 12'd1);
    end
    if (stall_lo < 0) chk("finish_cycle", fin_c, (len == 0) ? 1 : int'(len) + 3);
    wt_ready = 1'b1;
  endtask

  typedef struct {
    logic        req;
    logic        rdy;
    logic        rd_en;
    logic [11:0] addr;
    logic        vld;
    logic [15:0] data;
    logic        last;
    logic        fin;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // Layer 0, k=0, base 0, len 4, ready always high; index = cycle number.
    vecs[0] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 12'h001, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 12'h002, 1'b1, dval(12'h000), 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 12'h003, 1'b1, dval(12'h001), 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, dval(12'h002), 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b1, dval(12'h003), 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 16'h0000, 1'b0, 1'b1};

    rst            = 1'b0;
    req_valid      = 1'b0;
    req_k          = '0;
    req_layer      = '0;
    cfg_layer_base = '0;
    cfg_filter_len = '0;
    wt_ready       = 1'b1;
    #1;
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_rd_addr", mem_rd_addr, 0);
    chk("rst_wt_valid", wt_valid, 0);
    chk("rst_wt_data", wt_data, 0);
    chk("rst_wt_last", wt_last, 0);
    chk("rst_finish", stream_filter_finish, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic len-4 stream, cycle-exact.
    cfg_filter_len = 10'd4;
    for (int i = 0; i < 9; i++) begin
      req_valid = vecs[i].req;
      wt_ready  = vecs[i].rdy;
      @(negedge clk);
      chk("vec_rd_en", mem_rd_en, vecs[i].rd_en);
      if (vecs[i].rd_en) chk("vec_rd_addr", mem_rd_addr, vecs[i].addr);
      chk("vec_wt_valid", wt_valid, vecs[i].vld);
      if (vecs[i].vld) begin
        chk("vec_wt_data", wt_data, vecs[i].data);
        chk("vec_wt_last", wt_last, vecs[i].last);
      end
      chk("vec_finish", stream_filter_finish, vecs[i].fin);
      @(posedge clk);
      #1;
    end

    // Same key held in DONE: no new reads, finish stays high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_no_read", mem_rd_en, 0);
      chk("hold_finish", stream_filter_finish, 1);
      @(posedge clk);
      #1;
    end

    // Key change to k=1 from DONE starts a new stream.
    run_stream(3'd0, 6'd1, 12'h000, 10'd4, -1, -1);
    // k=2, base 0x100, len 5: addresses 0x10A..0x10E.
    run_stream(3'd0, 6'd2, 12'h100, 10'd5, -1, -1);
    // Zero-length filter.
    run_stream(3'd3, 6'd5, 12'h123, 10'd0, -1, -1);
    // Back-pressure from cycle 3 to cycle 8.
    run_stream(3'd1, 6'd0, 12'h200, 10'd4, 3, 8);

    // Reset during cycle 4 of a len-8 stream.
    req_valid      = 1'b1;
    req_layer      = 3'd2;
    req_k          = 6'd1;
    cfg_layer_base = 12'h300;
    cfg_filter_len = 10'd8;
    wt_ready       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_valid", wt_valid, 1);
    chk("pre_rst_data", wt_data, dval(12'h309));
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_rd_en", mem_rd_en, 0);
    chk("mid_rst_rd_addr", mem_rd_addr, 0);
    chk("mid_rst_wt_valid", wt_valid, 0);
    chk("mid_rst_wt_data", wt_data, 0);
    chk("mid_rst_wt_last", wt_last, 0);
    chk("mid_rst_finish", stream_filter_finish, 0);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_no_read", mem_rd_en, 0);
      chk("post_rst_no_valid", wt_valid, 0);
      chk("post_rst_no_finish", stream_filter_finish, 0);
      @(posedge clk);
      #1;
    end

    // Fresh request from IDLE after reset.
    run_stream(3'd0, 6'd3, 12'h040, 10'd3, -1, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
